// File: rtl/bp_pkg.sv
// Shared definitions for the gshare branch predictor.
//   bp_state_e  : table-initialisation FSM state
//   bp_idx_w    : table index width for a given hash mode
//   bp_hash     : PC/history hash to table index (32-bit result, caller truncates)
//   bp_ctr_next : saturating counter update
package bp_pkg;

  typedef enum logic {StInit, StRun} bp_state_e;

  // Index width: concatenation needs both fields side by side; XOR needs the wider of the two.
  function automatic int unsigned bp_idx_w(input int unsigned mode, input int unsigned ghr_w,
                                           input int unsigned pc_w);
    if (mode == 0) return ghr_w + pc_w;
    return (ghr_w > pc_w) ? ghr_w : pc_w;
  endfunction

  // pc_bits and ghr arrive zero-extended. Mode 0: {pc_bits, ghr}; mode 1: pc_bits ^ ghr.
  function automatic logic [31:0] bp_hash(input logic mode, input logic [31:0] pc_bits,
                                          input logic [31:0] ghr, input int unsigned ghr_w);
    if (!mode) return (pc_bits << ghr_w) | ghr;
    return pc_bits ^ ghr;
  endfunction

  // Counters are carried zero-extended to 4 bits; ctr_w sets the saturation ceiling.
  function automatic logic [3:0] bp_ctr_next(input logic [3:0] ctr, input logic taken,
                                             input int unsigned ctr_w);
    logic [4:0] max_w;
    logic [3:0] max_v;
    max_w = (5'd1 << ctr_w) - 5'd1;
    max_v = max_w[3:0];
    if (taken && (ctr < max_v)) return ctr + 4'd1;
    if (!taken && (ctr != 4'd0)) return ctr - 4'd1;
    return ctr;
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Pattern table of saturating counters.
//   clk            : clock
//   rd_idx_i/rd_ctr_o : combinational fetch read port (no write bypass)
//   init_we_i, init_idx_i, init_val_i : initialisation write, has priority
//   train_we_i, train_idx_i, train_taken_i : training read-modify-write
// Contents are undefined until the initialisation sweep completes.
module bp_counter_table
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W = 8,
  parameter int unsigned CTR_W = 2
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [CTR_W-1:0] rd_ctr_o,
  input  logic             init_we_i,
  input  logic [IDX_W-1:0] init_idx_i,
  input  logic [CTR_W-1:0] init_val_i,
  input  logic             train_we_i,
  input  logic [IDX_W-1:0] train_idx_i,
  input  logic             train_taken_i
);

  localparam int unsigned Depth = 1 << IDX_W;

  logic [CTR_W-1:0] mem_q [Depth];

  logic             we;
  logic [IDX_W-1:0] waddr;
  logic [CTR_W-1:0] wdata;
  logic [CTR_W-1:0] train_cur;
  logic [3:0]       train_cur4;
  logic [3:0]       train_nxt4;

  assign rd_ctr_o  = mem_q[rd_idx_i];
  assign train_cur = mem_q[train_idx_i];

  always_comb begin
    train_cur4                = '0;
    train_cur4[CTR_W-1:0]     = train_cur;
    train_nxt4                = bp_ctr_next(train_cur4, train_taken_i, CTR_W);
    we                        = init_we_i | train_we_i;
    waddr                     = train_idx_i;
    wdata                     = train_nxt4[CTR_W-1:0];
    if (init_we_i) begin
      waddr = init_idx_i;
      wdata = init_val_i;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  logic unused_nxt;
  assign unused_nxt = ^train_nxt4;

endmodule

// File: rtl/gshare_pred.sv
// gshare global-history branch predictor.
//   clk, rst (async, active-low)
//   Fetch : pcF -> registered prediction in Decode
//   Decode: stallD, flushD, branchD -> pred_takeD, ghr_snapD
//   Memory: branchM, pcM, actual_takeM, pred_takeM, ghr_snapM (training / recovery)
//   Status: ready (table initialised), branch_cnt, mispred_cnt
module gshare_pred
  import bp_pkg::*;
#(
  parameter int unsigned GHR_W     = 8,
  parameter int unsigned PC_IDX_W  = 4,
  parameter int unsigned CTR_W     = 2,
  parameter int unsigned HASH_MODE = 1,
  parameter int unsigned INIT_CTR  = (1 << (CTR_W - 1)) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pcF,
  input  logic             stallD,
  input  logic             flushD,
  input  logic             branchD,
  output logic             pred_takeD,
  output logic [GHR_W-1:0] ghr_snapD,
  input  logic             branchM,
  input  logic [31:0]      pcM,
  input  logic             actual_takeM,
  input  logic             pred_takeM,
  input  logic [GHR_W-1:0] ghr_snapM,
  output logic             ready,
  output logic [31:0]      branch_cnt,
  output logic [31:0]      mispred_cnt
);

  localparam int unsigned      IDX_W   = bp_idx_w(HASH_MODE, GHR_W, PC_IDX_W);
  localparam logic [IDX_W-1:0] LastIdx = '1;
  localparam logic [CTR_W-1:0] InitVal = CTR_W'(INIT_CTR);
  localparam logic             HashSel = (HASH_MODE != 0);

  bp_state_e        state_q, state_d;
  logic [IDX_W-1:0] init_idx_q, init_idx_d;
  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic             pred_q, pred_d;
  logic [GHR_W-1:0] snap_q, snap_d;
  logic [31:0]      bcnt_q, bcnt_d;
  logic [31:0]      mcnt_q, mcnt_d;

  logic             init_we;
  logic             misp;
  logic             train_we;
  logic [31:0]      fhash, mhash;
  logic [IDX_W-1:0] fetch_idx, train_idx;
  logic [CTR_W-1:0] fetch_ctr;

  // Index hashing: both ports use the same function so training lands where fetch looked.
  assign fhash     = bp_hash(HashSel, 32'(pcF[PC_IDX_W+1:2]), 32'(ghr_q), GHR_W);
  assign mhash     = bp_hash(HashSel, 32'(pcM[PC_IDX_W+1:2]), 32'(ghr_snapM), GHR_W);
  assign fetch_idx = fhash[IDX_W-1:0];
  assign train_idx = mhash[IDX_W-1:0];

  assign ready    = (state_q == StRun);
  assign misp     = ready & branchM & (pred_takeM ^ actual_takeM);
  assign train_we = ready & branchM;

  bp_counter_table #(
    .IDX_W (IDX_W),
    .CTR_W (CTR_W)
  ) u_table (
    .clk           (clk),
    .rd_idx_i      (fetch_idx),
    .rd_ctr_o      (fetch_ctr),
    .init_we_i     (init_we),
    .init_idx_i    (init_idx_q),
    .init_val_i    (InitVal),
    .train_we_i    (train_we),
    .train_idx_i   (train_idx),
    .train_taken_i (actual_takeM)
  );

  // Initialisation sweep: one entry per cycle, then park in StRun.
  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    init_we    = 1'b0;
    unique case (state_q)
      StInit: begin
        init_we    = 1'b1;
        init_idx_d = init_idx_q + 1'b1;
        if (init_idx_q == LastIdx) begin
          state_d    = StRun;
          init_idx_d = '0;
        end
      end
      StRun: ;
      default: state_d = StInit;
    endcase
  end

  assign pred_takeD = branchD & pred_q & ready;
  assign ghr_snapD  = snap_q;

  // Speculative history; a mispredict restores from the snapshot and drops any D shift.
  always_comb begin
    ghr_d = ghr_q;
    if (!ready) begin
      ghr_d = '0;
    end else if (misp) begin
      ghr_d = {ghr_snapM[GHR_W-2:0], actual_takeM};
    end else if (branchD && !stallD && !flushD) begin
      ghr_d = {ghr_q[GHR_W-2:0], pred_takeD};
    end
  end

  always_comb begin
    pred_d = pred_q;
    snap_d = snap_q;
    if (flushD) begin
      pred_d = 1'b0;
      snap_d = '0;
    end else if (!stallD) begin
      pred_d = fetch_ctr[CTR_W-1];
      snap_d = ghr_q;
    end
  end

  always_comb begin
    bcnt_d = bcnt_q;
    mcnt_d = mcnt_q;
    if (train_we) bcnt_d = bcnt_q + 32'd1;
    if (misp)     mcnt_d = mcnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StInit;
      init_idx_q <= '0;
      ghr_q      <= '0;
      pred_q     <= 1'b0;
      snap_q     <= '0;
      bcnt_q     <= '0;
      mcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      ghr_q      <= ghr_d;
      pred_q     <= pred_d;
      snap_q     <= snap_d;
      bcnt_q     <= bcnt_d;
      mcnt_q     <= mcnt_d;
    end
  end

  assign branch_cnt  = bcnt_q;
  assign mispred_cnt = mcnt_q;

  logic unused_bits;
  assign unused_bits = ^{pcF[31:PC_IDX_W+2], pcF[1:0], pcM[31:PC_IDX_W+2], pcM[1:0],
                         fhash[31:IDX_W], mhash[31:IDX_W]};

endmodule

// File: tb/tb_gshare_pred.sv
// Bench for gshare_pred at default parameters (mode 1, 256 entries, 2-bit counters).
module tb_gshare_pred;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcF, pcM;
  logic        stallD, flushD, branchD, branchM, actual_takeM, pred_takeM;
  logic [7:0]  ghr_snapM;
  logic        pred_takeD, ready;
  logic [7:0]  ghr_snapD;
  logic [31:0] branch_cnt, mispred_cnt;

  gshare_pred dut (
    .clk          (clk),
    .rst          (rst),
    .pcF          (pcF),
    .stallD       (stallD),
    .flushD       (flushD),
    .branchD      (branchD),
    .pred_takeD   (pred_takeD),
    .ghr_snapD    (ghr_snapD),
    .branchM      (branchM),
    .pcM          (pcM),
    .actual_takeM (actual_takeM),
    .pred_takeM   (pred_takeM),
    .ghr_snapM    (ghr_snapM),
    .ready        (ready),
    .branch_cnt   (branch_cnt),
    .mispred_cnt  (mispred_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: table of counter values, history as a plain integer.
  int          m_tbl [256];
  int          m_ghr;
  bit          m_pred_r;
  int          m_snap_r;
  int unsigned m_bcnt, m_mcnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int hidx(input logic [31:0] pc, input int ghr);
    return ((pc >> 2) & 15) ^ (ghr & 255);
  endfunction

  function automatic int sat(input int c, input bit t);
    if (t) return (c < 3) ? c + 1 : c;
    return (c > 0) ? c - 1 : c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_tbl[i] = 1;
    m_ghr    = 0;
    m_pred_r = 1'b0;
    m_snap_r = 0;
    m_bcnt   = 0;
    m_mcnt   = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_edge();
    bit pt, pf, misp;
    int old_ghr;
    pt      = branchD & m_pred_r;
    pf      = (m_tbl[hidx(pcF, m_ghr)] >= 2);
    misp    = branchM && (pred_takeM != actual_takeM);
    old_ghr = m_ghr;
    if (branchM) begin
      m_tbl[hidx(pcM, int'(ghr_snapM))] = sat(m_tbl[hidx(pcM, int'(ghr_snapM))], actual_takeM);
      m_bcnt++;
      if (misp) m_mcnt++;
    end
    if (misp) m_ghr = ((int'(ghr_snapM) << 1) | int'(actual_takeM)) & 255;
    else if (branchD && !stallD && !flushD) m_ghr = ((m_ghr << 1) | int'(pt)) & 255;
    if (flushD) begin
      m_pred_r = 1'b0;
      m_snap_r = 0;
    end else if (!stallD) begin
      m_pred_r = pf;
      m_snap_r = old_ghr;
    end
  endtask

  task automatic set_idle();
    pcF = 32'h0; pcM = 32'h0; stallD = 0; flushD = 0; branchD = 0;
    branchM = 0; actual_takeM = 0; pred_takeM = 0; ghr_snapM = 8'h0;
  endtask

  // One checked cycle in RUN: compare combinational outputs, clock, compare registers.
  task automatic cycle();
    #1;
    check("pred_takeD", {31'b0, pred_takeD}, {31'b0, branchD & m_pred_r});
    check("ghr_snapD", {24'b0, ghr_snapD}, 32'(m_snap_r));
    model_edge();
    @(posedge clk);
    #1;
    check("branch_cnt", branch_cnt, m_bcnt);
    check("mispred_cnt", mispred_cnt, m_mcnt);
  endtask

  // Release reset and verify ready timing: low after 255 edges, high after 256.
  task automatic run_init();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 255; i++) @(posedge clk);
    #1;
    check("ready_low_255", {31'b0, ready}, 32'd0);
    @(posedge clk);
    #1;
    check("ready_high_256", {31'b0, ready}, 32'd1);
  endtask

  bit          exp_p;
  int          exp_s;
  int unsigned prev_m;

  initial begin
    rst = 1'b0;
    set_idle();
    branchD = 1'b1;
    #12;
    check("rst_ready", {31'b0, ready}, 32'd0);
    check("rst_pred", {31'b0, pred_takeD}, 32'd0);
    check("rst_snap", {24'b0, ghr_snapD}, 32'd0);
    check("rst_bcnt", branch_cnt, 32'd0);
    check("rst_mcnt", mispred_cnt, 32'd0);
    branchD = 1'b0;

    run_init();
    model_reset();

    // Loop branch trained taken three times with history at 0.
    set_idle();
    branchM = 1; pcM = 32'h40; actual_takeM = 1; pred_takeM = 1;
    repeat (3) cycle();
    set_idle();
    pcF = 32'h40;
    cycle();
    branchD = 1;
    #1;
    check("loop_pred", {31'b0, pred_takeD}, 32'd1);
    cycle();

    // Same-entry read and write in one cycle: fetch sees the old value.
    set_idle();
    pcF = 32'h40; pcM = 32'h40; branchM = 1; actual_takeM = 1; pred_takeM = 1;
    ghr_snapM = 8'(m_ghr);
    cycle();
    set_idle();
    pcF = 32'h40; branchD = 1;
    #1;
    check("same_idx_old", {31'b0, pred_takeD}, 32'd0);
    cycle();
    #1;
    check("same_idx_new", {31'b0, pred_takeD}, 32'd1);
    cycle();

    // Mispredict alongside a Decode branch: recovery wins.
    set_idle();
    prev_m = m_mcnt;
    branchD = 1; branchM = 1; pcM = 32'h1c; ghr_snapM = 8'hA5; actual_takeM = 1; pred_takeM = 0;
    cycle();
    check("misp_cnt_inc", mispred_cnt, prev_m + 1);
    set_idle();
    cycle();
    check("misp_ghr", {24'b0, ghr_snapD}, 32'h4B);

    // Stall holds the Decode register while fetch wanders.
    set_idle();
    pcF = 32'h44;
    cycle();
    exp_p = m_pred_r;
    exp_s = m_snap_r;
    for (int i = 0; i < 3; i++) begin
      set_idle();
      stallD = 1; branchD = 1; pcF = $urandom;
      cycle();
      check("stall_snap", {24'b0, ghr_snapD}, 32'(exp_s));
      check("stall_pred", {31'b0, pred_takeD}, {31'b0, exp_p});
    end
    set_idle();
    stallD = 1; flushD = 1; branchD = 1;
    cycle();
    stallD = 0; flushD = 0;
    #1;
    check("flush_pred", {31'b0, pred_takeD}, 32'd0);
    check("flush_snap", {24'b0, ghr_snapD}, 32'd0);
    cycle();

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      pcF          = $urandom;
      pcM          = 32'($urandom_range(0, 3)) << 2;
      ghr_snapM    = 8'($urandom_range(0, 3));
      branchD      = 1'($urandom);
      stallD       = ($urandom_range(0, 4) == 0);
      flushD       = ($urandom_range(0, 9) == 0);
      branchM      = 1'($urandom);
      actual_takeM = 1'($urandom);
      pred_takeM   = 1'($urandom);
      cycle();
    end

    // Reset mid-initialisation restarts the sweep; M activity during INIT is ignored.
    @(posedge clk);
    #1;
    set_idle();
    rst = 1'b0;
    #1;
    check("rst2_ready", {31'b0, ready}, 32'd0);
    check("rst2_bcnt", branch_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    branchD = 1; branchM = 1; pred_takeM = 0; actual_takeM = 1; ghr_snapM = 8'h5A;
    repeat (100) @(posedge clk);
    #1;
    check("init_pred_low", {31'b0, pred_takeD}, 32'd0);
    check("init_bcnt", branch_cnt, 32'd0);
    rst = 1'b0;
    #1;
    run_init();
    check("init_mcnt", mispred_cnt, 32'd0);
    model_reset();
    set_idle();
    cycle();
    check("post_init_snap", {24'b0, ghr_snapD}, 32'd0);
    for (int i = 0; i < 60; i++) begin
      pcF          = $urandom;
      pcM          = 32'($urandom_range(0, 7)) << 2;
      ghr_snapM    = 8'($urandom);
      branchD      = 1'($urandom);
      stallD       = ($urandom_range(0, 4) == 0);
      flushD       = ($urandom_range(0, 9) == 0);
      branchM      = 1'($urandom);
      actual_takeM = 1'($urandom);
      pred_takeM   = 1'($urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
